// File: rtl/gba_io_pkg.sv
// Shared types and constants for the GBA I/O fabric.
//   arb_state_t  : sdram_arbiter FSM states
//   arb_owner_t  : owner of the SDRAM port (0 = GBA, 1 = USB)
//   SDRAM_ADDR_W : SDRAM byte-address width (0x2000_0000-byte space)
package gba_io_pkg;

    localparam int unsigned SDRAM_ADDR_W = 29;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StRdWait,
        StDone
    } arb_state_t;

    typedef enum logic {
        OwnGba = 1'b0,
        OwnUsb = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bus bundle around sdram_arbiter.
//   gba_*  : cartridge-bus request/ack (high priority)
//   usb_*  : mux side of the USB bridge port (low priority, level requests)
//   mem_*  : single SDRAM controller command/response port
//   arb_owner : owner of the current/last transaction
// Modports: slave = the arbiter, master = everything around it.
interface sdram_arbiter_if
    import gba_io_pkg::*;
#(
    parameter int unsigned ADDR_W = SDRAM_ADDR_W
);
    logic              gba_req;
    logic              gba_we;
    logic [ADDR_W-1:0] gba_addr;
    logic [31:0]       gba_wdata;
    logic [3:0]        gba_be;
    logic              gba_ack;
    logic [31:0]       gba_rdata;

    logic [31:0]       usb_addr;
    logic              usb_wr;
    logic [31:0]       usb_wr_data;
    logic              usb_wr_ready;
    logic              usb_rd;
    logic              usb_rd_valid;
    logic [31:0]       usb_rd_data;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    logic              arb_owner;

    modport slave (
        input  gba_req, gba_we, gba_addr, gba_wdata, gba_be,
        output gba_ack, gba_rdata,
        input  usb_addr, usb_wr, usb_wr_data, usb_rd,
        output usb_wr_ready, usb_rd_valid, usb_rd_data,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output arb_owner
    );

    modport master (
        output gba_req, gba_we, gba_addr, gba_wdata, gba_be,
        input  gba_ack, gba_rdata,
        output usb_addr, usb_wr, usb_wr_data, usb_rd,
        input  usb_wr_ready, usb_rd_valid, usb_rd_data,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  arb_owner
    );

endinterface

// File: rtl/sdram_arbiter.sv
// Two-client SDRAM port arbiter: GBA cartridge bus (priority) vs USB bridge
// (bulk). One transaction in flight; a starvation counter forces a USB grant
// after STARVE_LIMIT consecutive GBA grants while USB waits.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : sdram_arbiter_if.slave (GBA, USB and SDRAM signal groups)
module sdram_arbiter
    import gba_io_pkg::*;
#(
    parameter int unsigned ADDR_W       = SDRAM_ADDR_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    sdram_arbiter_if.slave bus
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [CntW-1:0]   starve_q, starve_d;
    logic [31:0]       gba_rdata_q, gba_rdata_d;
    logic [31:0]       usb_rd_data_q, usb_rd_data_d;

    logic usb_pend;
    logic usb_oor;
    logic grant_gba;
    logic grant_usb;

    assign usb_pend  = bus.usb_wr | bus.usb_rd;
    assign usb_oor   = |bus.usb_addr[31:ADDR_W];
    // GBA wins unless it has starved a waiting USB client for Limit grants.
    assign grant_gba = bus.gba_req & ((starve_q < Limit) | ~usb_pend);
    assign grant_usb = usb_pend & ~grant_gba;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            owner_q       <= OwnGba;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            starve_q      <= '0;
            gba_rdata_q   <= '0;
            usb_rd_data_q <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            starve_q      <= starve_d;
            gba_rdata_q   <= gba_rdata_d;
            usb_rd_data_q <= usb_rd_data_d;
        end
    end

    // Next-state and command latching.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        starve_d      = starve_q;
        gba_rdata_d   = gba_rdata_q;
        usb_rd_data_d = usb_rd_data_q;

        unique case (state_q)
            StIdle: begin
                if (grant_gba) begin
                    if (usb_pend) begin
                        if (starve_q != Limit) starve_d = starve_q + 1'b1;
                    end else begin
                        starve_d = '0;
                    end
                    owner_d = OwnGba;
                    we_d    = bus.gba_we;
                    addr_d  = bus.gba_addr;
                    wdata_d = bus.gba_wdata;
                    be_d    = bus.gba_be;
                    state_d = StIssue;
                end else if (grant_usb) begin
                    starve_d = '0;
                    owner_d  = OwnUsb;
                    we_d     = bus.usb_wr;  // write wins when both are raised
                    addr_d   = bus.usb_addr[ADDR_W-1:0];
                    wdata_d  = bus.usb_wr_data;
                    be_d     = 4'hF;
                    if (usb_oor) begin
                        // Out of range: no memory access, reads return zero.
                        if (!bus.usb_wr) usb_rd_data_d = '0;
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (bus.mem_gnt) state_d = we_q ? StDone : StRdWait;
            end
            StRdWait: begin
                if (bus.mem_rvalid) begin
                    if (owner_q == OwnGba) gba_rdata_d = bus.mem_rdata;
                    else                   usb_rd_data_d = bus.mem_rdata;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state. usb_rd_valid is additionally
    // gated by usb_rd so a withdrawn read (FIFO full) is silently discarded.
    always_comb begin
        bus.mem_req      = (state_q == StIssue);
        bus.mem_we       = we_q;
        bus.mem_addr     = addr_q;
        bus.mem_wdata    = wdata_q;
        bus.mem_be       = be_q;
        bus.gba_ack      = (state_q == StDone) && (owner_q == OwnGba);
        bus.gba_rdata    = gba_rdata_q;
        bus.usb_wr_ready = (state_q == StDone) && (owner_q == OwnUsb) && we_q;
        bus.usb_rd_valid = (state_q == StDone) && (owner_q == OwnUsb) && !we_q && bus.usb_rd;
        bus.usb_rd_data  = usb_rd_data_q;
        bus.arb_owner    = owner_q;
    end

endmodule
